// File: rtl/online_softmax_engine.sv
// online_softmax_engine
//
// Base-2 softmax over one row of signed integer scores. The row is streamed
// in once; a running maximum and a running sum of 2^(z - max) in fixed
// point (ONE = 2^EXP_FRAC) are kept during that single pass. Scores and mask
// bits are stored in a local buffer. A second pass re-reads every key,
// forms its exponential against the final maximum and divides it by the
// final sum with a bit-serial restoring divider.
//
// Ports
//   clk, rst_          : single rising-edge clock, asynchronous active-low reset
//   start, num_keys    : begin a row of num_keys scores (only honoured in IDLE)
//   s_valid/s_ready    : score stream handshake; s_score signed, s_mask excludes
//   m_valid/m_ready    : probability stream handshake
//   m_prob, m_idx      : probability (all fraction bits) and its key index
//   m_last             : marks the final key of the row
//   busy               : high whenever a row is in progress
//   done               : one-cycle pulse after the last probability is taken
//   all_masked         : the row had no unmasked score (held until next start)
//   err_len            : one-cycle pulse when start carries an illegal length
module online_softmax_engine #(
  parameter int SCORE_W  = 16,
  parameter int MAX_KEYS = 256,
  parameter int IDX_W    = $clog2(MAX_KEYS),
  parameter int EXP_FRAC = 11,
  parameter int SUM_W    = EXP_FRAC + 1 + IDX_W,
  parameter int OUT_W    = 12
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic [IDX_W:0]     num_keys,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SCORE_W-1:0] s_score,
  input  logic               s_mask,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_prob,
  output logic [IDX_W-1:0]   m_idx,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               all_masked,
  output logic               err_len
);

  localparam int D_W   = SCORE_W + 1;      // width of a score difference
  localparam int E_W   = EXP_FRAC + 1;     // width of one exponential term
  localparam int Q_W   = OUT_W + 1;        // quotient bits (ratio can reach 1.0)
  localparam int CNT_W = $clog2(Q_W + 1);

  localparam logic [E_W-1:0]   ONE_E      = {1'b1, {EXP_FRAC{1'b0}}};
  localparam logic [SUM_W-1:0] ONE_S      = SUM_W'(ONE_E);
  localparam logic [IDX_W:0]   MAX_KEYS_W = (IDX_W + 1)'(MAX_KEYS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INGEST,
    ST_FETCH,
    ST_DIVIDE,
    ST_OUTPUT
  } state_t;

  // 2^d in fixed point for d <= 0; vanishes once the shift empties ONE.
  function automatic logic [E_W-1:0] exp2_neg(input logic signed [D_W-1:0] d);
    logic [D_W-1:0] mag;
    mag = -d;
    if (mag >= D_W'(E_W)) begin
      exp2_neg = '0;
    end else begin
      exp2_neg = ONE_E >> mag;
    end
  endfunction

  state_t                     state_q, state_d;
  logic [IDX_W:0]             num_keys_q, num_keys_d;
  logic [IDX_W-1:0]           index_q, index_d;
  logic signed [SCORE_W-1:0]  max_q, max_d;
  logic [SUM_W-1:0]           sum_q, sum_d;
  logic                       seen_q, seen_d;
  logic                       all_masked_q, all_masked_d;
  logic                       fetch_ph_q, fetch_ph_d;
  logic [CNT_W-1:0]           div_cnt_q, div_cnt_d;
  logic [SUM_W:0]             rem_q, rem_d;
  logic [OUT_W:0]             num_q, num_d;
  logic [Q_W-1:0]             quo_q, quo_d;
  logic                       ezero_q, ezero_d;
  logic [OUT_W-1:0]           m_prob_q, m_prob_d;
  logic                       done_q, done_d;
  logic                       err_len_q, err_len_d;

  // Score buffer: {mask, score} per key, registered read port.
  logic [SCORE_W:0]           buf_mem [MAX_KEYS];
  logic [SCORE_W:0]           rd_q;
  logic                       wr_en;

  // Combinational helpers
  logic signed [D_W-1:0]      in_diff;
  logic [D_W-1:0]             up_sh;
  logic [SUM_W-1:0]           sum_shifted;
  logic signed [D_W-1:0]      fe_diff;
  logic [E_W-1:0]             e_j;
  logic [SUM_W:0]             trial;
  logic                       trial_ge;
  logic [Q_W-1:0]             quo_next;
  logic                       is_last;
  logic                       start_legal;

  assign wr_en = (state_q == ST_INGEST) && s_valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_mem[index_q] <= {s_mask, s_score};
    end
    rd_q <= buf_mem[index_q];
  end

  always_comb begin
    // Online-max helpers for the incoming score
    in_diff = $signed({s_score[SCORE_W-1], s_score}) - $signed({max_q[SCORE_W-1], max_q});
    up_sh   = in_diff;
    if (up_sh >= D_W'(SUM_W)) begin
      sum_shifted = '0;
    end else begin
      sum_shifted = sum_q >> up_sh;
    end

    // Exponential of the buffered key against the final maximum
    fe_diff = $signed({rd_q[SCORE_W-1], rd_q[SCORE_W-1:0]}) - $signed({max_q[SCORE_W-1], max_q});
    if (rd_q[SCORE_W] || all_masked_q) begin
      e_j = '0;
    end else begin
      e_j = exp2_neg(fe_diff);
    end

    // One restoring-divider step: shift in the next numerator bit, subtract if it fits
    trial    = {rem_q[SUM_W-1:0], num_q[OUT_W]};
    trial_ge = (trial >= {1'b0, sum_q});
    quo_next = {quo_q[Q_W-2:0], trial_ge};

    is_last     = ({1'b0, index_q} == (num_keys_q - 1'b1));
    start_legal = (num_keys != '0) && (num_keys <= MAX_KEYS_W);
  end

  always_comb begin
    state_d      = state_q;
    num_keys_d   = num_keys_q;
    index_d      = index_q;
    max_d        = max_q;
    sum_d        = sum_q;
    seen_d       = seen_q;
    all_masked_d = all_masked_q;
    fetch_ph_d   = fetch_ph_q;
    div_cnt_d    = div_cnt_q;
    rem_d        = rem_q;
    num_d        = num_q;
    quo_d        = quo_q;
    ezero_d      = ezero_q;
    m_prob_d     = m_prob_q;
    done_d       = 1'b0;
    err_len_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_legal) begin
            num_keys_d   = num_keys;
            max_d        = '0;
            sum_d        = '0;
            index_d      = '0;
            seen_d       = 1'b0;
            all_masked_d = 1'b0;
            state_d      = ST_INGEST;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end

      ST_INGEST: begin
        if (s_valid) begin
          if (!s_mask) begin
            if (!seen_q) begin
              max_d  = s_score;
              sum_d  = ONE_S;
              seen_d = 1'b1;
            end else if (in_diff > 0) begin
              // New maximum: rescale everything accumulated so far
              max_d = s_score;
              sum_d = sum_shifted + ONE_S;
            end else begin
              sum_d = sum_q + SUM_W'(exp2_neg(in_diff));
            end
          end
          if (is_last) begin
            index_d      = '0;
            fetch_ph_d   = 1'b0;
            all_masked_d = !(seen_q || !s_mask);
            state_d      = ST_FETCH;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end

      ST_FETCH: begin
        // Phase 0 lets the buffer read settle; phase 1 loads the divider.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          // Numerator is e_j << OUT_W. Its bits above position OUT_W form
          // the starting remainder (always below sum, so no quotient bits
          // are lost); the rest are shifted in one per cycle.
          rem_d     = (SUM_W + 1)'(e_j >> 1);
          num_d     = {e_j[0], {OUT_W{1'b0}}};
          quo_d     = '0;
          ezero_d   = (e_j == '0);
          div_cnt_d = '0;
          state_d   = ST_DIVIDE;
        end
      end

      ST_DIVIDE: begin
        if (trial_ge) begin
          rem_d = trial - {1'b0, sum_q};
        end else begin
          rem_d = trial;
        end
        num_d     = {num_q[OUT_W-1:0], 1'b0};
        quo_d     = quo_next;
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CNT_W'(OUT_W)) begin
          if (ezero_q) begin
            m_prob_d = '0;
          end else if (quo_next[OUT_W]) begin
            m_prob_d = '1;   // ratio of exactly 1.0 saturates
          end else begin
            m_prob_d = quo_next[OUT_W-1:0];
          end
          state_d = ST_OUTPUT;
        end
      end

      ST_OUTPUT: begin
        if (m_ready) begin
          if (is_last) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            index_d    = index_q + 1'b1;
            fetch_ph_d = 1'b0;
            state_d    = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= ST_IDLE;
      num_keys_q   <= '0;
      index_q      <= '0;
      max_q        <= '0;
      sum_q        <= '0;
      seen_q       <= 1'b0;
      all_masked_q <= 1'b0;
      fetch_ph_q   <= 1'b0;
      div_cnt_q    <= '0;
      rem_q        <= '0;
      num_q        <= '0;
      quo_q        <= '0;
      ezero_q      <= 1'b0;
      m_prob_q     <= '0;
      done_q       <= 1'b0;
      err_len_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_keys_q   <= num_keys_d;
      index_q      <= index_d;
      max_q        <= max_d;
      sum_q        <= sum_d;
      seen_q       <= seen_d;
      all_masked_q <= all_masked_d;
      fetch_ph_q   <= fetch_ph_d;
      div_cnt_q    <= div_cnt_d;
      rem_q        <= rem_d;
      num_q        <= num_d;
      quo_q        <= quo_d;
      ezero_q      <= ezero_d;
      m_prob_q     <= m_prob_d;
      done_q       <= done_d;
      err_len_q    <= err_len_d;
    end
  end

  assign s_ready    = (state_q == ST_INGEST);
  assign m_valid    = (state_q == ST_OUTPUT);
  assign m_prob     = m_prob_q;
  assign m_idx      = index_q;
  assign m_last     = (state_q == ST_OUTPUT) && is_last;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign all_masked = all_masked_q;
  assign err_len    = err_len_q;

endmodule

// File: tb/tb_online_softmax_engine.sv
// Testbench for online_softmax_engine: directed rows, a behavioural softmax
// model that produces the expected probability stream, and one compare
// process that checks every cycle m_valid is high plus the done pulse.
module tb_online_softmax_engine;

  localparam int SCORE_W  = 16;
  localparam int MAX_KEYS = 256;
  localparam int IDX_W    = 8;
  localparam int EXP_FRAC = 11;
  localparam int SUM_W    = 20;
  localparam int OUT_W    = 12;
  localparam int ONE      = 2048;
  localparam int PMAX     = 4095;

  logic               clk = 1'b0;
  logic               rst_ = 1'b0;
  logic               start = 1'b0;
  logic [IDX_W:0]     num_keys = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [SCORE_W-1:0] s_score = '0;
  logic               s_mask = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [OUT_W-1:0]   m_prob;
  logic [IDX_W-1:0]   m_idx;
  logic               m_last;
  logic               busy;
  logic               done;
  logic               all_masked;
  logic               err_len;

  online_softmax_engine #(
    .SCORE_W(SCORE_W), .MAX_KEYS(MAX_KEYS), .IDX_W(IDX_W),
    .EXP_FRAC(EXP_FRAC), .SUM_W(SUM_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_(rst_), .start(start), .num_keys(num_keys),
    .s_valid(s_valid), .s_ready(s_ready), .s_score(s_score), .s_mask(s_mask),
    .m_valid(m_valid), .m_ready(m_ready), .m_prob(m_prob), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .done(done), .all_masked(all_masked),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  int  row_sc [MAX_KEYS];
  bit  row_mk [MAX_KEYS];
  int  mdl_p  [MAX_KEYS];
  longint mdl_sum;
  bit  mdl_allm;

  function automatic void model(input int n);
    int mx = 0;
    bit seen = 0;
    longint s = 0;
    for (int i = 0; i < n; i++) begin
      if (!row_mk[i]) begin
        if (!seen) begin
          mx = row_sc[i]; s = ONE; seen = 1;
        end else if (row_sc[i] > mx) begin
          int sh = row_sc[i] - mx;
          s = ((sh >= SUM_W) ? 0 : (s >> sh)) + ONE;
          mx = row_sc[i];
        end else begin
          int d = mx - row_sc[i];
          s = s + ((d >= EXP_FRAC + 1) ? 0 : (ONE >> d));
        end
      end
    end
    mdl_sum  = s;
    mdl_allm = !seen;
    for (int j = 0; j < n; j++) begin
      longint e;
      longint p;
      int d = mx - row_sc[j];
      e = (row_mk[j] || !seen || d >= EXP_FRAC + 1) ? 0 : (ONE >> d);
      p = (e == 0) ? 0 : (e * 4096) / s;
      mdl_p[j] = (p > PMAX) ? PMAX : int'(p);
    end
  endfunction

  typedef struct { int prob; int idx; bit last; } exp_t;
  exp_t exp_q[$];

  // ---------------- compare process ----------------
  logic done_due = 1'b0;
  always @(negedge clk) begin
    if (!rst_) begin
      done_due <= 1'b0;
    end else begin
      check("done", done, done_due);
      done_due <= 1'b0;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("m_valid_spurious", m_valid, 1'b0);
        end else begin
          check("m_prob", m_prob, exp_q[0].prob);
          check("m_idx", m_idx, exp_q[0].idx);
          check("m_last", m_last, exp_q[0].last);
          if (m_ready) begin
            $display("xfer idx=%0d prob=%0d last=%0d", m_idx, m_prob, m_last);
            if (exp_q[0].last) done_due <= 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic start_and_feed(input int n, input int k);
    @(posedge clk); #1;
    start = 1'b1; num_keys = (IDX_W + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      int w = 0;
      s_valid = 1'b1;
      s_score = SCORE_W'(row_sc[i]);
      s_mask  = row_mk[i];
      @(negedge clk);
      while (!s_ready && w < 50) begin
        w++;
        @(negedge clk);
      end
      if (!s_ready) fail_bound("s_ready_wait");
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    s_valid = 1'b0;
  endtask

  task automatic begin_row(input int n);
    int w = 0;
    model(n);
    for (int j = 0; j < n; j++) exp_q.push_back('{prob: mdl_p[j], idx: j, last: (j == n - 1)});
    start_and_feed(n, n);
    do begin
      @(negedge clk);
      w++;
    end while (!m_valid && w < 100);
    if (m_valid) check("first_valid_latency", cyc - acc_cyc, OUT_W + 3);
    else fail_bound("first_valid_wait");
  endtask

  task automatic finish_row(input int n);
    int w = 0;
    while ((exp_q.size() != 0 || busy) && w < 40 * n + 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0 || busy) begin
      fail_bound("row_complete_wait");
      exp_q.delete();
    end
    check("all_masked", all_masked, mdl_allm);
  endtask

  task automatic run_row(input int n);
    begin_row(n);
    finish_row(n);
  endtask

  task automatic reset_and_check(input string tag);
    rst_ = 1'b0;
    #1;
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_prob"}, m_prob, 0);
    check({tag, "_m_idx"}, m_idx, 0);
    check({tag, "_m_last"}, m_last, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_all_masked"}, all_masked, 1'b0);
    check({tag, "_err_len"}, err_len, 1'b0);
    exp_q.delete();
    s_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic bad_len(input int n);
    @(posedge clk); #1;
    start = 1'b1; num_keys = (IDX_W + 1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_len_pulse", err_len, 1'b1);
    check("err_len_busy", busy, 1'b0);
    @(negedge clk);
    check("err_len_clear", err_len, 1'b0);
    check("err_len_busy2", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_and_check("reset");

    // Equal scores
    row_sc[0] = 3; row_mk[0] = 0; row_sc[1] = 3; row_mk[1] = 0;
    model(2);
    check("model_33_p0", mdl_p[0], 2048);
    check("model_33_p1", mdl_p[1], 2048);
    run_row(2);

    // Two scores one apart
    row_sc[0] = 0; row_sc[1] = 1;
    model(2);
    check("model_01_sum", 32'(mdl_sum), 3072);
    check("model_01_p0", mdl_p[0], 1365);
    check("model_01_p1", mdl_p[1], 2730);
    run_row(2);

    // Single key saturates
    row_sc[0] = -5; row_mk[0] = 0;
    model(1);
    check("model_single_p0", mdl_p[0], 4095);
    run_row(1);

    // Exponential underflows to zero
    row_sc[0] = 0; row_sc[1] = 20; row_mk[0] = 0; row_mk[1] = 0;
    model(2);
    check("model_0_20_p0", mdl_p[0], 0);
    check("model_0_20_p1", mdl_p[1], 4095);
    run_row(2);

    // Masked maximum is ignored
    row_sc[0] = 5; row_mk[0] = 1; row_sc[1] = 2; row_mk[1] = 0;
    model(2);
    check("model_mask_p0", mdl_p[0], 0);
    check("model_mask_p1", mdl_p[1], 4095);
    run_row(2);

    // Everything masked
    row_sc[0] = 1; row_mk[0] = 1; row_sc[1] = 1; row_mk[1] = 1;
    model(2);
    check("model_allm_flag", mdl_allm, 1'b1);
    check("model_allm_p0", mdl_p[0], 0);
    run_row(2);

    // Mixed row with rescaling, masking and underflow
    row_sc[0] = -3; row_sc[1] = 7; row_sc[2] = 7;  row_sc[3] = 2;
    row_sc[4] = 100; row_sc[5] = 6; row_sc[6] = -20; row_sc[7] = 5;
    for (int i = 0; i < 8; i++) row_mk[i] = (i == 4);
    model(8);
    check("model_mixed_sum", 32'(mdl_sum), 5698);
    run_row(8);

    // Consumer stall; start while busy is ignored
    for (int i = 0; i < 3; i++) begin row_sc[i] = 2; row_mk[i] = 0; end
    m_ready = 1'b0;
    begin_row(3);
    @(posedge clk); #1;
    start = 1'b1; num_keys = 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", m_valid, 1'b1);
      check("stall_prob", m_prob, 1365);
      check("stall_busy", busy, 1'b1);
    end
    m_ready = 1'b1;
    finish_row(3);
    repeat (3) begin
      @(negedge clk);
      check("ignored_start_idle", busy, 1'b0);
    end

    // Illegal lengths
    bad_len(0);
    bad_len(MAX_KEYS + 1);

    // Reset during ingest, then a full row
    for (int i = 0; i < 4; i++) begin row_sc[i] = i; row_mk[i] = 0; end
    start_and_feed(4, 2);
    reset_and_check("rst_ingest");
    row_sc[0] = 0; row_sc[1] = 1; row_mk[0] = 0; row_mk[1] = 0;
    run_row(2);

    // Reset during divide, then a full row
    row_sc[0] = 4; row_mk[0] = 0;
    start_and_feed(1, 1);
    repeat (5) @(posedge clk);
    #1;
    reset_and_check("rst_divide");
    row_sc[0] = 3; row_sc[1] = 3; row_mk[0] = 0; row_mk[1] = 0;
    run_row(2);

    // Full-length row
    for (int i = 0; i < MAX_KEYS; i++) begin
      row_sc[i] = ((i * 37) % 23) - 11;
      row_mk[i] = ((i % 11) == 3);
    end
    run_row(MAX_KEYS);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
